// File: rtl/timer_pkg.sv
// Shared definitions for the 32-bit match timer and its sequencing controller:
// TCR/MCR bit positions, canned register values and the sequencer state encoding.
package timer_pkg;

   localparam int TCR_EN  = 0;
   localparam int TCR_RST = 1;

   // Each match channel owns three consecutive MCR bits: interrupt, reset, stop.
   localparam int MCR_CH_STRIDE = 3;
   localparam int MCR_INT       = 0;
   localparam int MCR_RST       = 1;
   localparam int MCR_STOP      = 2;

   localparam logic [7:0] TCR_IDLE = 8'h00;
   localparam logic [7:0] TCR_HOLD = 8'(1 << TCR_RST);
   localparam logic [7:0] TCR_RUN  = 8'(1 << TCR_EN);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_LOAD,
      ST_RUN,
      ST_HALT
   } seq_state_e;

   function automatic logic [15:0] mcr_field(input int ch, input logic irq,
                                             input logic rst, input logic stp);
      logic [15:0] f;
      f = (16'(irq) << (ch * MCR_CH_STRIDE + MCR_INT))
        | (16'(rst) << (ch * MCR_CH_STRIDE + MCR_RST))
        | (16'(stp) << (ch * MCR_CH_STRIDE + MCR_STOP));
      return f;
   endfunction

   localparam logic [15:0] MCR_MR0_PERIODIC = mcr_field(0, 1'b1, 1'b1, 1'b0);

endpackage

// File: rtl/timer_sequencer.sv
// Run-command sequencer for the match timer: clears, loads PR/MR0/MCR, enables
// counting, counts MR0 matches and halts after the requested periods or on abort.
module timer_sequencer
   import timer_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic [WIDTH-1:0] prescale,
   input  logic [WIDTH-1:0] period,
   input  logic [CNT_W-1:0] repeat_cnt,
   input  logic             match,
   output logic [7:0]       tcr_val,
   output logic [WIDTH-1:0] pr_val,
   output logic [WIDTH-1:0] mr0_val,
   output logic [15:0]      mcr_val,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [CNT_W-1:0] tick_count
);

   seq_state_e       state_q;
   logic             clr_cnt_q;
   logic [WIDTH-1:0] prescale_q;
   logic [WIDTH-1:0] period_q;
   logic [CNT_W-1:0] repeat_q;
   logic [CNT_W-1:0] tick_count_q;
   logic [CNT_W-1:0] tick_count_d;
   logic             last_match_d;
   logic [7:0]       tcr_q;
   logic [WIDTH-1:0] pr_q;
   logic [WIDTH-1:0] mr0_q;
   logic [15:0]      mcr_q;
   logic             busy_q;
   logic             done_q;
   logic             aborted_q;

   // A repeat count of zero never completes; only stop ends a free run.
   always_comb begin
      tick_count_d = tick_count_q + CNT_W'(1);
      last_match_d = (repeat_q != '0) && (tick_count_d == repeat_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         clr_cnt_q    <= 1'b0;
         prescale_q   <= '0;
         period_q     <= '0;
         repeat_q     <= '0;
         tick_count_q <= '0;
         tcr_q        <= TCR_IDLE;
         pr_q         <= '0;
         mr0_q        <= '0;
         mcr_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               tcr_q <= TCR_IDLE;
               if (start) begin
                  prescale_q   <= prescale;
                  period_q     <= period;
                  repeat_q     <= repeat_cnt;
                  tick_count_q <= '0;
                  clr_cnt_q    <= 1'b0;
                  tcr_q        <= TCR_HOLD;
                  busy_q       <= 1'b1;
                  state_q      <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               if (stop) begin
                  state_q   <= ST_HALT;
                  tcr_q     <= TCR_HOLD;
                  done_q    <= 1'b1;
                  aborted_q <= 1'b1;
               end else if (clr_cnt_q) begin
                  pr_q    <= prescale_q;
                  mr0_q   <= period_q;
                  mcr_q   <= MCR_MR0_PERIODIC;
                  state_q <= ST_LOAD;
               end else begin
                  clr_cnt_q <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (stop) begin
                  state_q   <= ST_HALT;
                  tcr_q     <= TCR_HOLD;
                  done_q    <= 1'b1;
                  aborted_q <= 1'b1;
               end else begin
                  tcr_q   <= TCR_RUN;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (match) begin
                  tick_count_q <= tick_count_d;
               end
               // A coincident match is counted first, so it can still complete the run.
               if (match && last_match_d) begin
                  state_q   <= ST_HALT;
                  tcr_q     <= TCR_HOLD;
                  done_q    <= 1'b1;
                  aborted_q <= 1'b0;
               end else if (stop) begin
                  state_q   <= ST_HALT;
                  tcr_q     <= TCR_HOLD;
                  done_q    <= 1'b1;
                  aborted_q <= 1'b1;
               end
            end
            ST_HALT: begin
               tcr_q   <= TCR_IDLE;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               tcr_q   <= TCR_IDLE;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign tcr_val    = tcr_q;
   assign pr_val     = pr_q;
   assign mr0_val    = mr0_q;
   assign mcr_val    = mcr_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign aborted    = aborted_q;
   assign tick_count = tick_count_q;

endmodule

// File: doc/timer_sequencer.md
# timer_sequencer

Sequencing controller for the 32-bit match timer. It accepts a single run command (prescale, period, repeat count) and programs the timer's TCR/PR/MR0/MCR input values in a fixed order. It enables counting, counts MR0 match pulses, and then halts and resets the timer after the requested number of periods or on an abort. It sits between the system control logic and the timer's `*_VAL` configuration inputs.

## Interface
Parameters:
- `WIDTH`, 32, width of prescale/period values and of `pr_val`/`mr0_val`
- `CNT_W`, 8, width of `repeat_cnt` and `tick_count`

Ports:
- `clk`  in  1  single clock for the block
- `reset`  in  1  synchronous, active-high
- `start`  in  1  run request; sampled only in IDLE
- `stop`  in  1  abort request; honoured in CLEAR, LOAD, RUN
- `prescale`  in  WIDTH  prescale value, latched on accepted `start`
- `period`  in  WIDTH  MR0 match value, latched on accepted `start`
- `repeat_cnt`  in  CNT_W  periods to run; 0 = free-run until `stop`; latched on `start`
- `match`  in  1  one-cycle MR0 match pulse from the timer
- `tcr_val`  out  8  timer control value (bit0 enable, bit1 counter reset)
- `pr_val`  out  WIDTH  prescale register value
- `mr0_val`  out  WIDTH  match register 0 value
- `mcr_val`  out  16  match control value
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse
- `aborted`  out  1  valid with `done`; 1 = ended by `stop`
- `tick_count`  out  CNT_W  matches counted in the current or last run

## Operation
- States: IDLE, CLEAR, LOAD, RUN, HALT.
- **IDLE:** `tcr_val`=0x00. When `start`=1, latch the inputs, clear `tick_count`, and go to CLEAR. `match` is ignored in IDLE.
- **CLEAR:** held for exactly 2 cycles. `tcr_val`=0x02, which holds TC and PC in reset and covers the timer's one-cycle register latency.
- **LOAD:** 1 cycle.
  - `pr_val`=prescale, `mr0_val`=period.
  - `mcr_val`=0x0003 (MR0 interrupt + reset-on-match).
  - `tcr_val`=0x02.
- **RUN:** `tcr_val`=0x01. Each `match` pulse increments `tick_count`, which wraps at 2^CNT_W−1 → 0.
  - If `repeat_cnt`≠0 and the incremented count equals `repeat_cnt`, go to HALT with `aborted`=0.
  - If `stop`=1, go to HALT with `aborted`=1.
  - If `match` and `stop` arrive in the same cycle, the match is counted first. If that reaches `repeat_cnt`, `aborted`=0; otherwise `aborted`=1.
- **HALT:** 1 cycle. `tcr_val`=0x02 and `done`=1, then return to IDLE.
  - `pr_val`, `mr0_val` and `mcr_val` keep their values until the next LOAD.
  - `tick_count` holds its value until the next accepted `start`.
- `stop` in CLEAR or LOAD goes to HALT with `aborted`=1 and `tick_count`=0.
- `start` is ignored whenever `busy`=1.
- `period`=0 and `prescale`=0 are legal and are passed through unchanged.

## Timing
- Reset values:
  - State IDLE.
  - `tcr_val`=0x00, `pr_val`=0, `mr0_val`=0, `mcr_val`=0.
  - `busy`=0, `done`=0, `aborted`=0, `tick_count`=0.
- Reset takes effect at the next `clk` edge from any state, with no HALT and no `done` pulse.
- All outputs are registered.
- With `start` sampled at edge 0:
  - `busy`=1 and CLEAR run from edge 1 to edge 2.
  - LOAD is at edge 3.
  - RUN and `tcr_val`=0x01 start at edge 4.
- A `match` sampled at edge k updates `tick_count` at edge k+1. If that is the final match, HALT and `done` occur at edge k+1 and IDLE at edge k+2.
- `stop` sampled at edge k gives HALT at edge k+1.
- `start` can be accepted again in the cycle after HALT.

## Structure
- Shared package `timer_pkg` holds:
  - TCR bit indices (`TCR_EN`=0, `TCR_RST`=1).
  - MCR field constants per match channel (interrupt, reset, stop).
  - The state encoding.
- The timer module itself also uses `timer_pkg`.
- Single module, no sub-module. The FSM, input latch and tick counter are simple enough to live together.

## Test plan
- Reset mid-RUN with `tick_count`=3 → at the next edge: IDLE, all outputs at reset values, no `done`.
- `start` with prescale=4, period=9, repeat=3:
  - `tcr_val` sequence 0x02, 0x02, 0x02, 0x01 on edges 1–4.
  - LOAD shows `pr_val`=4, `mr0_val`=9, `mcr_val`=0x0003.
  - After 3 `match` pulses: `done`=1, `aborted`=0, `tick_count`=3, `tcr_val`=0x02.
- repeat=0 with 300 `match` pulses, then `stop` → `tick_count`=44 (wrapped), `done`=1, `aborted`=1.
- `match` and `stop` in the same cycle:
  - At count 1 with repeat=2 → `aborted`=0, `tick_count`=2.
  - At count 0 with repeat=5 → `aborted`=1, `tick_count`=1.
- `stop` during CLEAR → HALT next edge, `aborted`=1, `tick_count`=0.
- `start` pulsed during RUN → ignored, latched values unchanged.
